// File: rtl/sysid_regs_pkg.sv
// sysid_pkg: shared constants for the system ID / uptime register block.
//   - word addresses of the 8-entry register map
//   - bit positions inside CTRL and STATUS
//   - CTRL reset value (counter enabled out of reset)
package sysid_pkg;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_VERSION   = 3'd2;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd4;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd5;
  localparam logic [2:0] ADDR_CTRL      = 3'd6;
  localparam logic [2:0] ADDR_STATUS    = 3'd7;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CLR_BIT    = 1;
  localparam int STATUS_WRAP_BIT = 0;

  localparam logic [31:0] CTRL_RESET = 32'h1;

endpackage

// File: rtl/sysid_regs_if.sv
// sysid_regs_if: Avalon-MM style slave bus for the system ID block.
//   address[2:0]   word address
//   read, write    one-cycle strobes
//   writedata[31:0]
//   readdata[31:0] registered read data
//   readdatavalid  response strobe
//
// Handshake: there is no waitrequest. A strobe seen high at a rising clock
// edge is accepted at that edge. An accepted read is answered by
// readdatavalid=1 with readdata exactly one cycle later; readdata then holds
// until the next accepted read.
interface sysid_regs_if;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/sysid_regs_uptime_counter.sv
// uptime_counter: free-running up counter with synchronous clear.
//   clock, reset   clock and asynchronous active-high reset
//   en             count by 1 per clock while high
//   clr            zero the counter at the next edge (takes priority)
//   count          current counter value
//   wrap_pulse     high during the single cycle in which the counter steps
//                  from all-ones to zero (never while clr is high)
module uptime_counter #(
  parameter int COUNT_W = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               en,
  input  logic               clr,
  output logic [COUNT_W-1:0] count,
  output logic               wrap_pulse
);

  localparam logic [COUNT_W-1:0] INC = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + INC;
    end
  end

  // A clear in the same cycle suppresses the wrap event.
  assign wrap_pulse = en & ~clr & (&count_q);
  assign count      = count_q;

endmodule

// File: rtl/sysid_regs.sv
// sysid_regs: system ID / health peripheral, 8-word register map.
//   clock, reset  clock and asynchronous active-high reset
//   bus           sysid_regs_if slave port (address/read/write/writedata in,
//                 readdata/readdatavalid out, fixed read latency of 1)
// Map: 0 ID, 1 TIMESTAMP, 2 VERSION (constants), 3 SCRATCH (RW),
//      4 UPTIME_LO (also snapshots the high word), 5 UPTIME_HI (snapshot),
//      6 CTRL {clear(WO), enable}, 7 STATUS {wrap (sticky, W1C)}.
module sysid_regs
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'd102,
  parameter logic [31:0] TIMESTAMP = 32'd1526569095,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter int          COUNT_W   = 64
) (
  input  logic        clock,
  input  logic        reset,
  sysid_regs_if.slave bus
);

  logic [COUNT_W-1:0] count;
  logic               wrap_pulse;
  logic               ctrl_en;
  logic               ctrl_clr;
  logic               wrap_flag;
  logic               status_w1c;
  logic [31:0]        scratch;
  logic [31:0]        shadow_hi;
  logic [31:0]        count_hi;
  logic [31:0]        rd_mux;
  logic [31:0]        readdata_q;
  logic               readdatavalid_q;

  // Clear is a pure strobe from the CTRL write; nothing is stored for it.
  assign ctrl_clr   = bus.write && (bus.address == ADDR_CTRL) && bus.writedata[CTRL_CLR_BIT];
  assign status_w1c = bus.write && (bus.address == ADDR_STATUS) && bus.writedata[STATUS_WRAP_BIT];

  uptime_counter #(
    .COUNT_W (COUNT_W)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .en         (ctrl_en),
    .clr        (ctrl_clr),
    .count      (count),
    .wrap_pulse (wrap_pulse)
  );

  // High part of the live counter, zero-extended to a full word.
  always_comb begin
    count_hi = '0;
    count_hi[COUNT_W-33:0] = count[COUNT_W-1:32];
  end

  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_ID:        rd_mux = SYSTEM_ID;
      ADDR_TIMESTAMP: rd_mux = TIMESTAMP;
      ADDR_VERSION:   rd_mux = VERSION;
      ADDR_SCRATCH:   rd_mux = scratch;
      ADDR_UPTIME_LO: rd_mux = count[31:0];
      ADDR_UPTIME_HI: rd_mux = shadow_hi;
      ADDR_CTRL:      rd_mux[CTRL_EN_BIT] = ctrl_en;
      ADDR_STATUS:    rd_mux[STATUS_WRAP_BIT] = wrap_flag;
      default:        rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      scratch         <= '0;
      shadow_hi       <= '0;
      ctrl_en         <= CTRL_RESET[CTRL_EN_BIT];
      wrap_flag       <= 1'b0;
    end else begin
      readdatavalid_q <= bus.read;
      // Reads sample pre-write state, so a same-cycle write is not visible.
      if (bus.read) begin
        readdata_q <= rd_mux;
        // Latch the high word together with the low word so a later
        // UPTIME_HI read is coherent with this UPTIME_LO value.
        if (bus.address == ADDR_UPTIME_LO) begin
          shadow_hi <= count_hi;
        end
      end
      if (bus.write && (bus.address == ADDR_SCRATCH)) begin
        scratch <= bus.writedata;
      end
      if (bus.write && (bus.address == ADDR_CTRL)) begin
        ctrl_en <= bus.writedata[CTRL_EN_BIT];
      end
      // A new wrap beats a simultaneous W1C.
      if (wrap_pulse) begin
        wrap_flag <= 1'b1;
      end else if (status_w1c) begin
        wrap_flag <= 1'b0;
      end
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;

endmodule
